// File: rtl/hilo_md_ctrl.sv
// -----------------------------------------------------------------------------
// hilo_md_ctrl
//
// Execute-stage controller for the multiply/divide unit and the architectural
// HI/LO register pair.
//
// A MULT/DIV in EX starts the unit, and EX is stalled until the result is ready.
// The multiplier takes MUL_CYCLES cycles. The divider is a restoring divider
// that produces one quotient bit per cycle, so a divide takes 32 cycles.
// The result waits in DONE until the instruction actually leaves EX. It is then
// committed to HI/LO. If the instruction is flushed, the result is discarded.
// MTHI/MTLO write HI/LO directly. MFHI/MFLO read the committed registers.
//
// Ports
//   clk, rst     clock; synchronous active-high reset
//   ex_valid     valid instruction in EX
//   ex_mult      MULT/MULTU in EX
//   ex_div       DIV/DIVU in EX
//   ex_mdsign    1: signed multiply/divide
//   ex_hilowen   [1] write HI, [0] write LO (MTHI/MTLO)
//   ex_hiloren   2'b10 read HI, 2'b01 read LO
//   ex_rega      GPR[rs]: multiplicand / dividend / MTHI-MTLO data
//   ex_regb      GPR[rt]: multiplier / divisor
//   ex_hold      EX held by another stall source
//   flush        exception/eret flush of EX and younger stages
//   md_stall     EX must hold: multiply/divide not finished
//   md_busy      unit not idle
//   hilo_rdata   selected HI or LO (combinational)
//   hi, lo       architectural HI and LO
// -----------------------------------------------------------------------------
module hilo_md_ctrl #(
  parameter int MUL_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_mult,
  input  logic        ex_div,
  input  logic        ex_mdsign,
  input  logic [1:0]  ex_hilowen,
  input  logic [1:0]  ex_hiloren,
  input  logic [31:0] ex_rega,
  input  logic [31:0] ex_regb,
  input  logic        ex_hold,
  input  logic        flush,
  output logic        md_stall,
  output logic        md_busy,
  output logic [31:0] hilo_rdata,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  // The counter must reach 31 for a divide and MUL_CYCLES-1 for a multiply.
  localparam int CNT_MAX = (MUL_CYCLES > 32) ? MUL_CYCLES : 32;
  localparam int CNT_W   = $clog2(CNT_MAX);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic [CNT_W-1:0] cnt;

  // Multiplier operands. Each is 33 bits, extended by the sign bit when the
  // operation is signed and by zero when it is unsigned.
  logic [32:0] mul_a;
  logic [32:0] mul_b;

  // Divider working registers. div_quo starts out holding |dividend|. Each
  // step shifts one dividend bit out of div_quo into div_rem and shifts one
  // quotient bit in at the bottom of div_quo.
  logic [31:0] div_rem;
  logic [31:0] div_quo;
  logic [31:0] div_den;
  logic        sign_q;
  logic        sign_r;

  logic [31:0] res_hi;
  logic [31:0] res_lo;

  logic start;
  logic mul_last;
  logic div_last;
  logic commit;
  logic mt_we;

  assign start    = ex_valid & (ex_mult | ex_div) & ~flush & (state == S_IDLE);
  assign mul_last = (cnt == CNT_W'(MUL_CYCLES - 1));
  assign div_last = (cnt == CNT_W'(31));
  assign commit   = (state == S_DONE) & ~ex_hold & ~flush;
  assign mt_we    = ex_valid & ~ex_mult & ~ex_div & (|ex_hilowen) & ~ex_hold & ~flush;

  assign md_busy    = (state != S_IDLE);
  assign hilo_rdata = ex_hiloren[1] ? hi : lo;

  // ---------------------------------------------------------------------------
  // Operand conditioning at start
  // ---------------------------------------------------------------------------
  logic        neg_a;
  logic        neg_b;
  logic [31:0] abs_a;
  logic [31:0] abs_b;

  assign neg_a = ex_mdsign & ex_rega[31];
  assign neg_b = ex_mdsign & ex_regb[31];
  // The magnitude of 0x80000000 is 0x80000000 when the value is read as
  // unsigned, so the overflow case 0x80000000 / -1 needs no special handling.
  assign abs_a = neg_a ? -ex_rega : ex_rega;
  assign abs_b = neg_b ? -ex_regb : ex_regb;

  // ---------------------------------------------------------------------------
  // Multiplier: only the low 64 bits of the product are kept. For these bits a
  // 64x64 product of the sign-extended operands is identical to the full
  // 33x33 signed product.
  // ---------------------------------------------------------------------------
  logic [63:0] mul_a_x;
  logic [63:0] mul_b_x;
  logic [63:0] prod;

  assign mul_a_x = {{31{mul_a[32]}}, mul_a};
  assign mul_b_x = {{31{mul_b[32]}}, mul_b};
  assign prod    = mul_a_x * mul_b_x;

  // ---------------------------------------------------------------------------
  // One restoring divide step. trial_diff is 34 bits wide so that its MSB is a
  // reliable borrow flag for any 33-bit partial remainder.
  // A divisor of zero never borrows. The quotient then comes out all ones and
  // the remainder comes out as the dividend. After the sign fix-up this is the
  // defined divide-by-zero result, so no separate path is needed.
  // ---------------------------------------------------------------------------
  logic [32:0] trial_rem;
  logic [33:0] trial_diff;
  logic        trial_ok;
  logic [31:0] step_rem;
  logic [31:0] step_quo;

  assign trial_rem  = {div_rem, div_quo[31]};
  assign trial_diff = {1'b0, trial_rem} - {2'b00, div_den};
  assign trial_ok   = ~trial_diff[33];
  assign step_rem   = trial_ok ? trial_diff[31:0] : trial_rem[31:0];
  assign step_quo   = {div_quo[30:0], trial_ok};

  // ex_hiloren[0] is implied by ex_hiloren[1] being low. Bit 32 of trial_diff
  // is always zero whenever the trial result is kept.
  logic unused;
  assign unused = ^{ex_hiloren[0], trial_diff[32]};

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state is updated with non-blocking assignments, so every
  // always_ff block reads the values from before the edge regardless of the
  // order in which the blocks are evaluated.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // ---------------------------------------------------------------------------
  // FSM next state and stall
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block gets a default before the case statement.
  // A path that leaves one of them unassigned would infer a latch.
  always_comb begin
    state_next = state;
    md_stall   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          md_stall   = 1'b1;
          state_next = ex_mult ? S_MUL : S_DIV;
        end
      end
      S_MUL: begin
        md_stall = 1'b1;
        if (flush)         state_next = S_IDLE;
        else if (mul_last) state_next = S_DONE;
      end
      S_DIV: begin
        md_stall = 1'b1;
        if (flush)         state_next = S_IDLE;
        else if (div_last) state_next = S_DONE;
      end
      S_DONE: begin
        // Leave DONE once the instruction moves on, with or without a commit.
        // The commit itself is decided by the commit signal.
        if (flush || !ex_hold) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: operand capture, iteration, result latch
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      mul_a   <= '0;
      mul_b   <= '0;
      div_rem <= '0;
      div_quo <= '0;
      div_den <= '0;
      sign_q  <= 1'b0;
      sign_r  <= 1'b0;
      res_hi  <= '0;
      res_lo  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            cnt <= '0;
            if (ex_mult) begin
              mul_a <= {ex_mdsign & ex_rega[31], ex_rega};
              mul_b <= {ex_mdsign & ex_regb[31], ex_regb};
            end else begin
              div_rem <= '0;
              div_quo <= abs_a;
              div_den <= abs_b;
              // The quotient sign follows both operands. The remainder sign
              // follows the dividend.
              sign_q  <= neg_a ^ neg_b;
              sign_r  <= neg_a;
            end
          end
        end
        S_MUL: begin
          cnt <= cnt + CNT_W'(1);
          if (mul_last) begin
            res_hi <= prod[63:32];
            res_lo <= prod[31:0];
          end
        end
        S_DIV: begin
          cnt     <= cnt + CNT_W'(1);
          div_rem <= step_rem;
          div_quo <= step_quo;
          if (div_last) begin
            res_lo <= sign_q ? -step_quo : step_quo;
            res_hi <= sign_r ? -step_rem : step_rem;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Architectural HI/LO. A completed mult/div commits when its instruction
  // leaves EX unflushed. MTHI/MTLO write when their instruction leaves EX.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else if (commit) begin
      hi <= res_hi;
      lo <= res_lo;
    end else if (mt_we) begin
      if (ex_hilowen[1]) hi <= ex_rega;
      if (ex_hilowen[0]) lo <= ex_rega;
    end
  end

endmodule

// File: doc/hilo_md_ctrl.md
Name: hilo_md_ctrl

Overview:
- Execute-stage controller for the multiply/divide resource and the architectural HI/LO pair.
- Takes decoded mult/div/mdsign/hilowen/hiloren controls plus rs/rt operands for the instruction in EX.
- Sequences a multi-cycle multiplier and a 32-iteration restoring divider, and stalls EX while busy.
- Commits HI/LO only when the instruction leaves EX unflushed, and serves MFHI/MFLO reads.

Parameters:
MUL_CYCLES, 2, cycles spent in MUL state (>=1); product registered at end of last one

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
ex_valid  in  1  valid instruction in EX
ex_mult  in  1  MULT/MULTU
ex_div  in  1  DIV/DIVU
ex_mdsign  in  1  1: signed operation
ex_hilowen  in  2  [1]: write HI, [0]: write LO (MTHI/MTLO, or 2'b11 for mult/div)
ex_hiloren  in  2  2'b10 read HI, 2'b01 read LO
ex_rega  in  32  GPR[rs]: multiplicand/dividend, or MTHI/MTLO data
ex_regb  in  32  GPR[rt]: multiplier/divisor
ex_hold  in  1  EX held by another stall source (instruction not leaving)
flush  in  1  exception/eret flush of EX and younger
md_stall  out  1  EX must hold: mult/div not finished
md_busy  out  1  state != IDLE
hilo_rdata  out  32  ex_hiloren[1] ? hi : lo (combinational)
hi  out  32  architectural HI
lo  out  32  architectural LO

Behaviour:
- Reset (sync, rst=1 at posedge): state=IDLE, hi=lo=0, cnt=0, result regs=0; md_busy=0, md_stall=0. Reset mid-operation aborts with no HI/LO write.
- start = ex_valid & (ex_mult|ex_div) & ~flush & state==IDLE.
- md_stall = start | state==MUL | state==DIV. It is 0 in IDLE without start and 0 in DONE.
- States:
  - IDLE: on start, latch operands and go to MUL (cnt=0) or DIV (cnt=0). For DIV latch |a| and |b| when signed; store sign_q = a[31]^b[31], sign_r = a[31]. Cycle S = start cycle.
  - MUL: cnt++. At cnt==MUL_CYCLES-1, latch the 64-bit product (signed: 33x33 sign-extended, unsigned: zero-extended) into res_hi/res_lo and go to DONE. md_stall is high for cycles S..S+MUL_CYCLES.
  - DIV: one restoring step per cycle, MSB first (shift remainder, trial subtract, set quotient bit). At cnt==31, latch sign-fixed results: LO=quotient, HI=remainder, go to DONE. md_stall is high for S..S+32 (33 cycles).
  - DONE: md_stall=0.
    - If ~ex_hold & ~flush: commit hi<=res_hi, lo<=res_lo, go to IDLE.
    - If flush (with or without ex_hold): no commit, go to IDLE.
    - Else (ex_hold, no flush): stay in DONE and commit on release.
- flush in MUL/DIV: go to IDLE next cycle, no commit, result discarded.
- Signed divide: quotient truncates toward zero; remainder takes the dividend's sign.
- Divide by zero (defined): HI=ex_rega. LO=0xFFFFFFFF if unsigned, or if signed and rega>=0; LO=0x00000001 if signed and rega<0.
- Signed overflow 0x80000000/0xFFFFFFFF: LO=0x80000000, HI=0.
- MTHI/MTLO: when ex_valid & ~ex_mult & ~ex_div & ex_hilowen!=0 & ~ex_hold & ~flush, write ex_rega into the selected register(s) at the edge. Nothing is written while ex_hold=1.
- Reads: hilo_rdata reflects committed registers only. No bypass: a commit is visible the cycle after the writer leaves EX.
- Simultaneous start & flush: no start. ex_valid with mult/div while not IDLE cannot occur (EX stalled); it is ignored.

Test Plan:
- Signed mult, rega=0xFFFFFFFE, regb=3, MUL_CYCLES=2 → md_stall high 3 cycles; after DONE, HI=0xFFFFFFFF, LO=0xFFFFFFFA. Unsigned, same operands → HI=0x00000002, LO=0xFFFFFFFA.
- DIVU 100/7 → md_stall high 33 cycles, then LO=0x0000000E, HI=0x00000002. Signed -7/2 (0xFFFFFFF9, 2) → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- Signed 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0. DIVU 5/0 → LO=0xFFFFFFFF, HI=5.
- Signed DIV with flush at S+10 → state IDLE at S+11, md_stall=0, HI/LO keep prior values (preload via MTHI 0x1234 → HI=0x1234 unchanged).
- MULTU 2x3 with ex_hold=1 for 3 DONE cycles → HI/LO unchanged during hold, LO=6/HI=0 after release edge, exactly one commit. Same with flush during DONE → no commit.
- MTLO 0xCAFE then MFLO the next cycle → hilo_rdata=0xCAFE. rst asserted mid-DIV → next cycle md_busy=0, hi=lo=0.
